uart_tx_arbiter: RTL and testbench

//  Shares one uart transmitter among NUM_REQ byte producers (message

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin sharing of one uart transmitter among NUM_REQ byte producers.
//   For each granted byte it drives data + dataReady, waits for the uart to
//   raise busy, waits for busy to fall, then pulses req_ack for the winner.
//   If busy never rises within BUSY_TIMEOUT cycles the byte is aborted and
//   req_err is pulsed instead (BUSY_TIMEOUT = 0 disables the abort).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | arbitrating; skipped for one cycle after any ack/err pulse
//   WAIT_BUSY | dataReady high, waiting for uart busy (timeout running)
//   WAIT_IDLE | uart accepted the byte, waiting for busy to fall
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   req_valid       per-requester byte pending
//   req_data        byte i at req_data[8*i+7:8*i]
//   req_ack/req_err one-cycle completion / abort pulse for the winner
//   uart_data       byte to the uart (holds last value after completion)
//   uart_dataReady  handshake strobe to the uart
//   uart_busy       busy flag from the uart
//   grant_id        index of the current / last winner
//   active          high whenever the FSM is not in IDLE
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 1024,
   localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     req_err,
   output logic [7:0]             uart_data,
   output logic                   uart_dataReady,
   input  logic                   uart_busy,
   output logic [ID_W-1:0]        grant_id,
   output logic                   active
);

   localparam int TMO_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_IDLE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [7:0]          data_d;
   logic                dr_d;
   logic [ID_W-1:0]     gid_d;
   logic [NUM_REQ-1:0]  ack_d, err_d;

   logic                found;
   int                  win_int;
   int                  idx;
   logic [ID_W-1:0]     next_ptr;

   // First valid index at or after rr_q, searching upward with wrap.
   always_comb begin
      found   = 1'b0;
      win_int = 0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            win_int = idx;
         end
      end
   end

   assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      tmo_d   = tmo_q;
      data_d  = uart_data;
      dr_d    = uart_dataReady;
      gid_d   = grant_id;
      ack_d   = '0;
      err_d   = '0;
      case (state_q)
         IDLE: begin
            // Registered ack/err still high means we just finished: bubble.
            if (req_ack == '0 && req_err == '0 && found) begin
               data_d  = req_data[8*win_int +: 8];
               dr_d    = 1'b1;
               gid_d   = win_int[ID_W-1:0];
               tmo_d   = '0;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // busy takes priority over a timeout landing on the same edge
            if (uart_busy) begin
               dr_d    = 1'b0;
               state_d = WAIT_IDLE;
            end else if (BUSY_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
               dr_d            = 1'b0;
               err_d[grant_id] = 1'b1;
               rr_d            = next_ptr;
               state_d         = IDLE;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (!uart_busy) begin
               ack_d[grant_id] = 1'b1;
               rr_d            = next_ptr;
               state_d         = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_q           <= '0;
         tmo_q          <= '0;
         uart_data      <= '0;
         uart_dataReady <= 1'b0;
         grant_id       <= '0;
         req_ack        <= '0;
         req_err        <= '0;
         active         <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_q           <= rr_d;
         tmo_q          <= tmo_d;
         uart_data      <= data_d;
         uart_dataReady <= dr_d;
         grant_id       <= gid_d;
         req_ack        <= ack_d;
         req_err        <= err_d;
         active         <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Scoreboarded bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16).
//   Expected grants (id, byte, dataReady length, abort flag) are queued as
//   requests are loaded; a negedge monitor pops them on each dataReady rise
//   and checks the matching ack/err pulse. A small uart model raises busy a
//   programmable number of cycles after dataReady and holds it 10 cycles.
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_ack, req_err;
   logic [7:0]      uart_data;
   logic            uart_dataReady;
   logic            uart_busy = 1'b0;
   logic [1:0]      grant_id;
   logic            active;

   uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ack        (req_ack),
      .req_err        (req_err),
      .uart_data      (uart_data),
      .uart_dataReady (uart_dataReady),
      .uart_busy      (uart_busy),
      .grant_id       (grant_id),
      .active         (active)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      int         id;
      logic [7:0] data;
      int         len;
      bit         err;
   } exp_t;

   exp_t exp_q[$];

   int cnt[NR];
   int seq[NR];

   function automatic logic [7:0] byte_val(input int i, input int n);
      logic [3:0] hi, lo;
      hi = 4'(i + 5);
      lo = 4'(n + 1);
      return {hi, lo};
   endfunction

   task automatic push(input int id, input int off, input int len, input bit err);
      exp_t e;
      e.id   = id;
      e.data = byte_val(id, seq[id] + off);
      e.len  = len;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]        = (cnt[i] != 0);
         req_data[8*i +: 8]  = byte_val(i, seq[i]);
      end
   endtask

   // uart model
   int busy_dly   = 3;
   bit busy_stuck = 1'b0;
   int bcnt = 0;
   int hcnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         uart_busy = 1'b0;
         bcnt = 0;
         hcnt = 0;
      end else if (uart_busy) begin
         hcnt++;
         if (hcnt >= 10) begin
            uart_busy = 1'b0;
            hcnt = 0;
         end
      end else if (uart_dataReady && !busy_stuck) begin
         bcnt++;
         if (bcnt >= busy_dly) begin
            uart_busy = 1'b1;
            bcnt = 0;
         end
      end else begin
         bcnt = 0;
      end
   end

   // monitor / scoreboard
   bit   pending   = 1'b0;
   bit   dr_prev   = 1'b0;
   int   dr_len    = 0;
   int   since_done = 100;
   bit   bubble_on = 1'b0;
   exp_t cur;

   always @(negedge clk) begin
      if (reset) begin
         pending = 1'b0;
         dr_prev = 1'b0;
         dr_len  = 0;
      end else begin
         since_done++;
         if (uart_dataReady && !dr_prev) begin
            if (exp_q.size() == 0) begin
               chk("grant_unexpected", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               chk("grant_id", 32'(grant_id), cur.id);
               chk("uart_data", 32'(uart_data), 32'(cur.data));
               chk("active_grant", 32'(active), 1);
               if (bubble_on && since_done <= 5) chk("bubble", since_done, 2);
               pending = 1'b1;
            end
            dr_len = 0;
         end
         if (uart_dataReady) dr_len++;
         if (!uart_dataReady && dr_prev && pending) chk("dr_len", dr_len, cur.len);
         if (req_ack != '0 || req_err != '0) begin
            if (!pending) begin
               chk("done_unexpected", 32'({req_err, req_ack}), 0);
            end else begin
               chk("req_ack", 32'(req_ack), cur.err ? 0 : (1 << cur.id));
               chk("req_err", 32'(req_err), cur.err ? (1 << cur.id) : 0);
               chk("active_done", 32'(active), 0);
               chk("data_hold", 32'(uart_data), 32'(cur.data));
               pending = 1'b0;
            end
            since_done = 0;
         end
         dr_prev = uart_dataReady;
      end
   end

   task automatic wait_done(input int budget, input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (req_ack[i] || req_err[i]) begin
               if (cnt[i] > 0) cnt[i]--;
               seq[i]++;
            end
         end
         drive_reqs();
         if (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0 &&
             !active && !uart_dataReady && req_ack == '0 && req_err == '0 &&
             exp_q.size() == 0 && !pending) begin
            done = 1'b1;
            break;
         end
      end
      chk({"finish_", tag}, 32'(done), 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"},   32'(req_ack), 0);
      chk({tag, "_err"},   32'(req_err), 0);
      chk({tag, "_data"},  32'(uart_data), 0);
      chk({tag, "_dr"},    32'(uart_dataReady), 0);
      chk({tag, "_gid"},   32'(grant_id), 0);
      chk({tag, "_active"}, 32'(active), 0);
   endtask

   initial begin
      bit ok;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < NR; i++) begin
         cnt[i] = 0;
         seq[i] = 0;
      end
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // single byte from requester 0 (0x51), dataReady high 3 cycles
      cnt[0] = 1;
      push(0, 0, 3, 0);
      chk("single_byte", 32'(byte_val(0, 0)), 32'h51);
      drive_reqs();
      wait_done(100, "single");

      // grant 2 alone (pointer -> 3), then 0101 wraps to 0 before 2
      cnt[2] = 1;
      push(2, 0, 3, 0);
      drive_reqs();
      wait_done(100, "grant2");
      cnt[0] = 1;
      cnt[2] = 1;
      push(0, 0, 3, 0);
      push(2, 0, 3, 0);
      drive_reqs();
      wait_done(200, "wrap");

      // busy stuck low: requester 1 aborted after 16 cycles of dataReady
      busy_stuck = 1'b1;
      cnt[1] = 1;
      push(1, 0, 16, 1);
      drive_reqs();
      wait_done(100, "timeout");
      busy_stuck = 1'b0;
      // pointer now 2: requesters 0,1,2 served as 2,0,1
      cnt[0] = 1;
      cnt[1] = 1;
      cnt[2] = 1;
      push(2, 0, 3, 0);
      push(0, 0, 3, 0);
      push(1, 0, 3, 0);
      drive_reqs();
      wait_done(300, "after_tmo");

      // busy rises on the timeout edge: no error, normal ack
      busy_dly = 16;
      cnt[3] = 1;
      push(3, 0, 16, 0);
      drive_reqs();
      wait_done(100, "tmo_edge");
      busy_dly = 3;

      // round robin with everyone held: 0,1,2,3,0 with one bubble each
      bubble_on = 1'b1;
      cnt[0] = 2;
      cnt[1] = 1;
      cnt[2] = 1;
      cnt[3] = 1;
      push(0, 0, 3, 0);
      push(1, 0, 3, 0);
      push(2, 0, 3, 0);
      push(3, 0, 3, 0);
      push(0, 1, 3, 0);
      drive_reqs();
      wait_done(400, "rr");
      bubble_on = 1'b0;

      // reset while in WAIT_IDLE: outputs clear at once, no ack, pointer back to 0
      cnt[1] = 1;
      push(1, 0, 3, 0);
      drive_reqs();
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (active && !uart_dataReady) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_wait_idle", 32'(ok), 1);
      #2;
      reset = 1'b1;
      cnt[1] = 0;
      drive_reqs();
      #1;
      check_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cnt[0] = 1;
      cnt[1] = 1;
      push(0, 0, 3, 0);
      push(1, 0, 3, 0);
      drive_reqs();
      wait_done(200, "post_reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
